fma_arbiter: RTL and testbench

FMA_ARBITER -- requirements
Module: fma_arbiter

---
 rtl/fma_arbiter.sv | 130 +++++++++++++
 tb/tb_fma_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fma_arbiter.sv
// Round-robin arbiter sharing one FMA_32 pipeline among NUM_REQ requesters, with drain/halt control.
// Optional accepted-operation counter on issue_count when FMA_ARB_STATS_EN is defined.
module fma_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int FMA_LATENCY = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*32-1:0]  req_a,
  input  logic [NUM_REQ*32-1:0]  req_b,
  input  logic [NUM_REQ*32-1:0]  req_c,
  output logic [31:0]            fma_a,
  output logic [31:0]            fma_b,
  output logic [31:0]            fma_c,
  output logic                   fma_in_valid,
  input  logic [31:0]            fma_result,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [31:0]            rsp_data,
  input  logic                   drain_req,
  output logic                   drain_done,
  output logic                   busy,
  output logic [31:0]            issue_count,
  output logic [1:0]             dbg_state
);

  // Handshake: a requester transfers when req_valid[i] && req_ready[i] in the same
  // cycle; req_ready is combinational and never depends on anything but RUN state,
  // rr_ptr and req_valid. Responses carry no backpressure.

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      grant_idx;
  logic [IW:0]        cand;
  logic               grant_found;
  logic               xfer;
  logic [IW-1:0]      fma_idx;
  logic [FMA_LATENCY-1:0] tag_v;
  logic [IW-1:0]      tag_idx [FMA_LATENCY];

  // Search starting at rr_ptr and wrapping; first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (!grant_found && req_valid[cand[IW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IW-1:0];
      end
    end
  end

  assign req_ready = (state == RUN && grant_found) ? (NUM_REQ'(1) << grant_idx) : '0;
  assign xfer      = |(req_valid & req_ready);
  assign busy      = fma_in_valid | (|tag_v) | (|rsp_valid);
  assign drain_done = (state == HALTED);
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (drain_req) state_next = DRAIN;
      DRAIN:   if (!busy)     state_next = HALTED;
      HALTED:  if (!drain_req) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Issue register, tag pipeline aligned with FMA_32, and response register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      fma_a        <= '0;
      fma_b        <= '0;
      fma_c        <= '0;
      fma_in_valid <= 1'b0;
      fma_idx      <= '0;
      tag_v        <= '0;
      for (int k = 0; k < FMA_LATENCY; k++) tag_idx[k] <= '0;
      rsp_valid    <= '0;
      rsp_data     <= '0;
    end else begin
      fma_in_valid <= xfer;
      if (xfer) begin
        rr_ptr  <= (grant_idx == IW'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
        fma_a   <= req_a[32*grant_idx +: 32];
        fma_b   <= req_b[32*grant_idx +: 32];
        fma_c   <= req_c[32*grant_idx +: 32];
        fma_idx <= grant_idx;
      end
      tag_v[0]   <= fma_in_valid;
      tag_idx[0] <= fma_idx;
      for (int k = 1; k < FMA_LATENCY; k++) begin
        tag_v[k]   <= tag_v[k-1];
        tag_idx[k] <= tag_idx[k-1];
      end
      rsp_valid <= tag_v[FMA_LATENCY-1] ? (NUM_REQ'(1) << tag_idx[FMA_LATENCY-1]) : '0;
      if (tag_v[FMA_LATENCY-1]) rsp_data <= fma_result;
    end
  end

`ifdef FMA_ARB_STATS_EN
  logic [31:0] issue_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    issue_cnt_q <= '0;
    else if (xfer) issue_cnt_q <= issue_cnt_q + 32'd1;
  end
  assign issue_count = issue_cnt_q;
`else
  assign issue_count = '0;
`endif

endmodule

// File: tb/tb_fma_arbiter.sv
// Self-checking bench for fma_arbiter: reference arbitration model plus response scoreboard,
// with a behavioural FMA_32 stand-in of matching latency.
module tb_fma_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int FMA_LATENCY = 3;
  localparam int W           = 66;
  localparam int M_RUN = 0, M_DRAIN = 1, M_HALTED = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    req_valid = '0;
  logic [3:0]    req_ready;
  logic [127:0]  req_a = '0, req_b = '0, req_c = '0;
  logic [31:0]   fma_a, fma_b, fma_c;
  logic          fma_in_valid;
  logic [31:0]   fma_result;
  logic [3:0]    rsp_valid;
  logic [31:0]   rsp_data;
  logic          drain_req = 1'b0;
  logic          drain_done;
  logic          busy;
  logic [31:0]   issue_count;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [W-1:0] exp_q[$];

  fma_arbiter #(.NUM_REQ(NUM_REQ), .FMA_LATENCY(FMA_LATENCY)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
    .fma_in_valid(fma_in_valid), .fma_result(fma_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .drain_req(drain_req), .drain_done(drain_done),
    .busy(busy), .issue_count(issue_count), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // FMA_32 stand-in; exact for the 1*2+1 vector, a distinct mixing function otherwise.
  function automatic logic [31:0] fake_fma(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
    if (a == 32'h3F800000 && b == 32'h40000000 && c == 32'h3F800000) return 32'h40400000;
    return (a ^ {b[15:0], b[31:16]}) + c;
  endfunction

  logic [31:0] fpipe [FMA_LATENCY];
  always @(posedge clk) begin
    for (int k = FMA_LATENCY-1; k > 0; k--) fpipe[k] <= fpipe[k-1];
    fpipe[0] <= fma_in_valid ? fake_fma(fma_a, fma_b, fma_c) : 32'hDEADBEEF;
  end
  assign fma_result = fpipe[FMA_LATENCY-1];

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[32*i +: 32] = $urandom();
      req_b[32*i +: 32] = $urandom();
      req_c[32*i +: 32] = $urandom();
    end
  endtask

  task automatic apply_reset();
    step();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- reference model + scoreboard ----------------
  int          m_state, m_ptr, m_last_busy, m_count, g, cand_i;
  bit          found, m_busy, m_prev_xfer;
  logic [3:0]  e_ready;
  logic [W-1:0] e;

  task automatic scoreboard_monitor();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_state = M_RUN; m_ptr = 0; m_prev_xfer = 0; m_last_busy = cyc; m_count = 0;
        exp_q.delete();
      end else begin
        found = 0; g = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
          cand_i = (m_ptr + k) % NUM_REQ;
          if (!found && req_valid[cand_i]) begin found = 1; g = cand_i; end
        end
        e_ready = (m_state == M_RUN && found) ? (4'b1 << g) : 4'b0;
        m_busy  = (cyc <= m_last_busy);

        n_checks++;
        if (req_ready !== e_ready) begin
          n_fail++; $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_ready);
        end
        n_checks++;
        if (fma_in_valid !== m_prev_xfer || busy !== m_busy ||
            drain_done !== (m_state == M_HALTED)) begin
          n_fail++;
          $display("FAIL ctrl cyc=%0d in_valid=%b busy=%b done=%b exp %b %b %b", cyc,
                   fma_in_valid, busy, drain_done, m_prev_xfer, m_busy, m_state == M_HALTED);
        end
        n_checks++;
`ifdef FMA_ARB_STATS_EN
        if (issue_count !== 32'(m_count)) begin
`else
        if (issue_count !== 32'd0) begin
`endif
          n_fail++; $display("FAIL issue_count cyc=%0d got=%0d model=%0d", cyc, issue_count, m_count);
        end
        n_checks++;
        if (exp_q.size() > 0 && int'(exp_q[0][65:34]) == cyc) begin
          e = exp_q.pop_front();
          if (rsp_valid !== (4'b1 << e[33:32]) || rsp_data !== e[31:0]) begin
            n_fail++;
            $display("FAIL rsp cyc=%0d got=%b/%h exp=%b/%h", cyc, rsp_valid, rsp_data,
                     4'b1 << e[33:32], e[31:0]);
          end
        end else if (rsp_valid !== 4'b0) begin
          n_fail++; $display("FAIL rsp_unexpected cyc=%0d got=%b exp=0000", cyc, rsp_valid);
        end

        if (e_ready != 4'b0) begin
          exp_q.push_back({32'(cyc + 2 + FMA_LATENCY), 2'(g),
                           fake_fma(req_a[32*g +: 32], req_b[32*g +: 32], req_c[32*g +: 32])});
          m_ptr = (g + 1) % NUM_REQ;
          m_last_busy = cyc + 2 + FMA_LATENCY;
          m_count++;
        end
        m_prev_xfer = (e_ready != 4'b0);
        case (m_state)
          M_RUN:    if (drain_req)  m_state = M_DRAIN;
          M_DRAIN:  if (!m_busy)    m_state = M_HALTED;
          default:  if (!drain_req) m_state = M_RUN;
        endcase
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #3;
    n_checks++;
    if ({req_ready, fma_in_valid, rsp_valid, busy, drain_done, dbg_state} !== '0) begin
      n_fail++; $display("FAIL reset_ctrl got=%b exp=0", {req_ready, fma_in_valid, rsp_valid, busy, drain_done, dbg_state});
    end
    n_checks++;
    if ({fma_a, fma_b, fma_c, rsp_data} !== '0) begin
      n_fail++; $display("FAIL reset_data got=%h exp=0", {fma_a, fma_b, fma_c, rsp_data});
    end
    n_checks++;
    if (issue_count !== 32'd0) begin
      n_fail++; $display("FAIL reset_count got=%0d exp=0", issue_count);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single_op();
    step();
    req_a = '0; req_b = '0; req_c = '0;
    req_a[31:0] = 32'h3F800000; req_b[31:0] = 32'h40000000; req_c[31:0] = 32'h3F800000;
    req_valid = 4'b0001;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL single_ready got=%b exp=0001", req_ready);
    end
    step();
    req_valid = 4'b0000;
    n_checks++;
    if (fma_in_valid !== 1'b1 || fma_a !== 32'h3F800000 || fma_b !== 32'h40000000 || fma_c !== 32'h3F800000) begin
      n_fail++; $display("FAIL single_issue got=%b %h %h %h exp=1 3f800000 40000000 3f800000", fma_in_valid, fma_a, fma_b, fma_c);
    end
    repeat (3) step();
    n_checks++;
    if (rsp_valid !== 4'b0000) begin
      n_fail++; $display("FAIL single_early got=%b exp=0000", rsp_valid);
    end
    step();
    n_checks++;
    if (rsp_valid !== 4'b0001 || rsp_data !== 32'h40400000) begin
      n_fail++; $display("FAIL single_rsp got=%b/%h exp=0001/40400000", rsp_valid, rsp_data);
    end
    step();
  endtask

  task automatic test_all_four();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      randomize_ops();
      req_valid = 4'hF;
      #1;
      n_checks++;
      if (req_ready !== (4'b1 << (i % 4))) begin
        n_fail++; $display("FAIL all_four_grant i=%0d got=%b exp=%b", i, req_ready, 4'b1 << (i % 4));
      end
      step();
    end
    req_valid = '0;
    repeat (8) step();
  endtask

  task automatic test_rr_1010();
    logic [3:0] exp_seq [4];
    exp_seq[0] = 4'b1000; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b1000; exp_seq[3] = 4'b0010;
    randomize_ops();
    req_valid = 4'b0010;
    step();
    for (int i = 0; i < 4; i++) begin
      randomize_ops();
      req_valid = 4'b1010;
      #1;
      n_checks++;
      if (req_ready !== exp_seq[i]) begin
        n_fail++; $display("FAIL rr_1010 i=%0d got=%b exp=%b", i, req_ready, exp_seq[i]);
      end
      step();
    end
    req_valid = '0;
    repeat (8) step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      randomize_ops();
      req_valid = 4'($urandom_range(0, 15));
      #1;
      n_checks++;
      if (!$onehot0(req_ready) || (req_ready & ~req_valid) != 4'b0 || (req_valid != 0 && req_ready == 0)) begin
        n_fail++; $display("FAIL b2b_ready i=%0d got=%b valid=%b", i, req_ready, req_valid);
      end
      step();
    end
    req_valid = '0;
    repeat (8) step();
  endtask

  task automatic test_drain();
    int busy_low;
    bit done;
    for (int i = 0; i < 3; i++) begin
      randomize_ops();
      req_valid = 4'hF;
      step();
    end
    req_valid = '0;
    drain_req = 1'b1;
    step();
    req_valid = 4'hF;
    #1;
    n_checks++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL drain_ready got=%b exp=0000", req_ready);
    end
    busy_low = -1; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (drain_done) begin
        done = 1;
        n_checks++;
        if (busy_low != i - 1) begin
          n_fail++; $display("FAIL drain_done_timing busy_low_at=%0d done_at=%0d exp_gap=1", busy_low, i);
        end
      end else begin
        if (!busy && busy_low < 0) busy_low = i;
        step();
      end
    end
    if (!done) begin
      n_checks++; n_fail++; $display("FAIL drain_timeout got=0 exp=1");
    end
    drain_req = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 4'b0000 || drain_done !== 1'b1) begin
      n_fail++; $display("FAIL halted_hold got=%b/%b exp=0000/1", req_ready, drain_done);
    end
    step();
    n_checks++;
    if (!$onehot(req_ready) || drain_done !== 1'b0) begin
      n_fail++; $display("FAIL resume got=%b/%b exp=onehot/0", req_ready, drain_done);
    end
    step();
    req_valid = '0;
    repeat (8) step();
  endtask

  task automatic test_drain_same_cycle();
    bit done;
    randomize_ops();
    req_valid = 4'b0100;
    drain_req = 1'b1;
    #1;
    n_checks++;
    if (!$onehot(req_ready)) begin
      n_fail++; $display("FAIL same_cycle_ready got=%b exp=onehot", req_ready);
    end
    step();
    req_valid = '0;
    n_checks++;
    if (fma_in_valid !== 1'b1) begin
      n_fail++; $display("FAIL same_cycle_issue got=%b exp=1", fma_in_valid);
    end
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (drain_done) done = 1;
      else step();
    end
    n_checks++;
    if (!done) begin
      n_fail++; $display("FAIL same_cycle_timeout got=0 exp=1");
    end
    drain_req = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_reset_mid();
    bit seen;
    for (int i = 0; i < 2; i++) begin
      randomize_ops();
      req_valid = 4'b0011;
      step();
    end
    req_valid = '0;
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, fma_in_valid, rsp_valid, busy, drain_done} !== '0) begin
      n_fail++; $display("FAIL mid_reset_ctrl got=%b exp=0", {req_ready, fma_in_valid, rsp_valid, busy, drain_done});
    end
    n_checks++;
    if ({fma_a, fma_b, fma_c, rsp_data} !== '0 || issue_count !== 32'd0) begin
      n_fail++; $display("FAIL mid_reset_data got=%h/%0d exp=0/0", {fma_a, fma_b, fma_c, rsp_data}, issue_count);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rsp_valid !== 4'b0) seen = 1;
    end
    n_checks++;
    if (seen) begin
      n_fail++; $display("FAIL mid_reset_ghost got=1 exp=0");
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    fork
      scoreboard_monitor();
    join_none
    test_reset();
    test_single_op();
    test_all_four();
    test_rr_1010();
    test_back_to_back();
    test_drain();
    test_drain_same_cycle();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL leftover got=%0d exp=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
